window_gen: RTL and testbench
=============================

WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 Parameter KERNEL_SIZE, default 3, window side K (K >= 2).
REQ-003 Parameter IMG_WIDTH, default 8, pixels per line W (W >= K).
REQ-004 Parameter IMG_HEIGHT, default 8, lines per frame H (H >= K).
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 pixel_in  input  DATA_WIDTH  raster-order pixel.
REQ-008 pixel_valid  input  1  pixel_in is valid this cycle.
REQ-009 pixel_ready  output  1  block accepts a pixel this cycle.
REQ-010 window  output  DATA_WIDTH*K*K  KxK window; element (r,c) at bits [(r*K+c+1)*DATA_WIDTH-1 -: DATA_WIDTH]; r=0 is the oldest line, c=0 is the leftmost column.
REQ-011 window_valid  output  1  window holds a valid window.
REQ-012 window_ready  input  1  consumer takes the window this cycle.
REQ-013 frame_done  output  1  high with the last window of a frame.

Function
REQ-014 A pixel is accepted when pixel_valid and pixel_ready are both high in the same cycle; no other condition accepts a pixel.
REQ-015 pixel_ready SHALL equal !window_valid || window_ready (combinational, one-deep output stage).
REQ-016 The block SHALL hold K-1 line buffers of W pixels each plus a KxK shift register; column counter col_cnt counts 0..W-1 and row counter row_cnt counts 0..H-1, both advancing only on acceptance.
REQ-017 col_cnt SHALL wrap W-1 -> 0 and increment row_cnt; on the last pixel of a frame (row_cnt=H-1, col_cnt=W-1), both counters SHALL return to 0.
REQ-018 FSM states are IDLE, FILL and RUN.
REQ-019 IDLE -> FILL on the first acceptance of a frame.
REQ-020 FILL -> RUN on acceptance of pixel (K-1, K-1).
REQ-021 RUN -> IDLE on acceptance of the last pixel of the frame.
REQ-022 An accepted pixel at (row_cnt >= K-1, col_cnt >= K-1) SHALL produce a window registered on that same edge, so latency is 1 cycle from acceptance to window_valid.
REQ-023 The produced window SHALL contain pixels rows row_cnt-K+1..row_cnt by columns col_cnt-K+1..col_cnt; stride is 1 and there is no padding.
REQ-024 Each frame SHALL produce exactly (H-K+1)*(W-K+1) windows.
REQ-025 Pixels accepted at col_cnt < K-1 or row_cnt < K-1 SHALL update the buffers only and SHALL NOT assert window_valid.
REQ-026 While window_valid=1 and window_ready=0, window, window_valid and frame_done SHALL hold and no pixel SHALL be accepted.
REQ-027 When window_valid=1, window_ready=1 and no window-producing acceptance occurs, window_valid SHALL fall on the next edge.
REQ-028 When the window is consumed and a window-producing pixel is accepted in the same cycle, window_valid SHALL stay 1 with the new window (no bubble).
REQ-029 frame_done SHALL be 1 exactly while the window from pixel (H-1, W-1) is presented, and 0 otherwise.
REQ-030 Gaps in pixel_valid SHALL NOT alter the contents or ordering of any window.
REQ-031 A pixel arriving in the cycle after a frame's last pixel SHALL start a new frame with no dead cycle.

Reset
REQ-032 On rst=1, asynchronously: window_valid=0, frame_done=0, window=0, counters=0, FSM=IDLE; line-buffer contents are don't-care.
REQ-033 pixel_ready SHALL be 1 during and immediately after reset.
REQ-034 Reset mid-frame SHALL discard the partial frame; the next accepted pixel is pixel (0,0) of a new frame.

Verification (K=3, W=H=4, DATA_WIDTH=8 unless stated)
REQ-035 Pixels 0..15, valid every cycle, window_ready=1 -> 4 windows.
- First window {0,1,2,4,5,6,8,9,10} one cycle after pixel 10 is accepted.
- Then {1,2,3,5,6,7,9,10,11}, then the windows ending at 14 and 15.
- frame_done=1 only with the window ending at 15.
REQ-036 window_ready=0 for 5 cycles after the first window -> window stays {0,1,2,4,5,6,8,9,10} and pixel_ready=0 throughout; streaming resumes with no window lost.
REQ-037 pixel_valid toggled 1/0 every cycle -> the same 4 windows as REQ-035, in the same order.
REQ-038 rst pulsed after pixel 7, then pixels 100..115 -> first window {100,101,102,104,105,106,108,109,110}, with no trace of the earlier data.
REQ-039 Two back-to-back frames (0..15, then 16..31) -> 8 windows, frame_done twice, second frame's first window {16,17,18,20,21,22,24,25,26}.
REQ-040 W=8, H=3 -> exactly 6 windows, and frame_done on the sixth.

Source files
------------

// File: rtl/window_gen_if.sv
// Stream bundle for window_gen: raster pixel input side and KxK window output side.
// The window generator itself sits on the slave modport.
interface window_gen_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int KERNEL_SIZE = 3
);
   logic [DATA_WIDTH-1:0]                         pixel_in;
   logic                                          pixel_valid;
   logic                                          pixel_ready;
   logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] window;
   logic                                          window_valid;
   logic                                          window_ready;
   logic                                          frame_done;

   modport slave (
      input  pixel_in, pixel_valid, window_ready,
      output pixel_ready, window, window_valid, frame_done
   );

   modport master (
      output pixel_in, pixel_valid, window_ready,
      input  pixel_ready, window, window_valid, frame_done
   );
endinterface

// File: rtl/window_gen.sv
// Sliding KxK window generator over a raster image: K-1 line buffers feed a KxK
// shift register, and each window-producing pixel loads a one-deep output stage.
//
// state | meaning
// IDLE  | waiting for pixel (0,0) of a frame
// FILL  | buffering the first K-1 lines / columns, no window yet
// RUN   | windows being produced until the last pixel of the frame
module window_gen #(
   parameter int DATA_WIDTH  = 8,
   parameter int KERNEL_SIZE = 3,
   parameter int IMG_WIDTH   = 8,
   parameter int IMG_HEIGHT  = 8
) (
   input  logic          clk,
   input  logic          rst,
   window_gen_if.slave   bus
);
   localparam int K  = KERNEL_SIZE;
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_K1   = CW'(K - 1);
   localparam logic [RW-1:0] ROW_K1   = RW'(K - 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   state_t                      state_q, state_d;
   logic [CW-1:0]               col_q, col_d;
   logic [RW-1:0]               row_q, row_d;
   logic                        valid_q, valid_d;
   logic                        done_q, done_d;
   logic [DATA_WIDTH*K*K-1:0]   win_q, win_d, win_nxt;

   logic [DATA_WIDTH-1:0]       lb_q [K-1][IMG_WIDTH];
   logic [DATA_WIDTH-1:0]       sr_q [K][K];
   logic [DATA_WIDTH-1:0]       sr_d [K][K];
   logic [DATA_WIDTH-1:0]       col_pix [K];

   logic accept, col_last, row_last, frame_last, produce;

   assign bus.pixel_ready  = !valid_q || bus.window_ready;
   assign bus.window       = win_q;
   assign bus.window_valid = valid_q;
   assign bus.frame_done   = done_q;

   assign accept     = bus.pixel_valid && bus.pixel_ready;
   assign col_last   = (col_q == COL_LAST);
   assign row_last   = (row_q == ROW_LAST);
   assign frame_last = col_last && row_last;
   assign produce    = accept && (col_q >= COL_K1) && (row_q >= ROW_K1);

   // Column slice for the current x position: oldest line first, incoming pixel last.
   always_comb begin
      for (int r = 0; r < K - 1; r++) col_pix[r] = lb_q[r][col_q];
      col_pix[K-1] = bus.pixel_in;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) sr_d[r][c] = sr_q[r][c+1];
         sr_d[r][K-1] = col_pix[r];
      end
      win_nxt = '0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            win_nxt[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = sr_d[r][c];
   end

   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      valid_d = valid_q;
      done_d  = done_q;
      win_d   = win_q;
      state_d = state_q;
      if (accept) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
      if (produce) begin
         valid_d = 1'b1;
         done_d  = frame_last;
         win_d   = win_nxt;
      end else if (bus.window_ready) begin
         valid_d = 1'b0;
         done_d  = 1'b0;
      end
      case (state_q)
         IDLE: if (accept) state_d = FILL;
         FILL: begin
            if (accept && frame_last)
               state_d = IDLE;
            else if (accept && col_q == COL_K1 && row_q == ROW_K1)
               state_d = RUN;
         end
         RUN:  if (accept && frame_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         win_q   <= win_d;
      end
   end

   // Buffer contents are fully rewritten before any window uses them, so no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int r = 0; r < K - 2; r++) lb_q[r][col_q] <= lb_q[r+1][col_q];
         lb_q[K-2][col_q] <= bus.pixel_in;
         sr_q <= sr_d;
      end
   end
endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen: a 4x4 instance for streaming, stall, gap, reset and
// back-to-back frames, and an 8x3 instance for the non-square frame case.
module tb_window_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   window_gen_if #(.DATA_WIDTH(8), .KERNEL_SIZE(3)) ifa ();
   window_gen_if #(.DATA_WIDTH(8), .KERNEL_SIZE(3)) ifb ();

   window_gen #(.DATA_WIDTH(8), .KERNEL_SIZE(3), .IMG_WIDTH(4), .IMG_HEIGHT(4))
      u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
   window_gen #(.DATA_WIDTH(8), .KERNEL_SIZE(3), .IMG_WIDTH(8), .IMG_HEIGHT(3))
      u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

   logic [71:0] cap_a_w[$];
   bit          cap_a_d[$];
   logic [71:0] cap_b_w[$];
   bit          cap_b_d[$];

   always @(negedge clk) begin
      if (ifa.window_valid && ifa.window_ready) begin
         cap_a_w.push_back(ifa.window);
         cap_a_d.push_back(ifa.frame_done);
      end
      if (ifb.window_valid && ifb.window_ready) begin
         cap_b_w.push_back(ifb.window);
         cap_b_d.push_back(ifb.frame_done);
      end
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [71:0] exp_win(input int base, input int w, input int wr, input int wc);
      logic [71:0] x;
      x = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            x[(r*3+c)*8 +: 8] = 8'(base + (wr + r) * w + wc + c);
      return x;
   endfunction

   task automatic send(input int sel, input int v);
      int n;
      logic rdy;
      n = 0;
      if (sel == 0) begin ifa.pixel_valid = 1'b1; ifa.pixel_in = 8'(v); end
      else          begin ifb.pixel_valid = 1'b1; ifb.pixel_in = 8'(v); end
      while (n < 50) begin
         @(negedge clk);
         rdy = (sel == 0) ? ifa.pixel_ready : ifb.pixel_ready;
         if (rdy) break;
         n++;
      end
      if (n >= 50) chk($sformatf("accept timeout px %0d", v), 1, 0);
      @(posedge clk); #1;
      if (sel == 0) ifa.pixel_valid = 1'b0;
      else          ifb.pixel_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      ifa.pixel_valid = 1'b0;
      ifb.pixel_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rst wv", ifa.window_valid, 0);
      chk("rst pready", ifa.pixel_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("post-rst pready", ifa.pixel_ready, 1);
      cap_a_w.delete(); cap_a_d.delete();
      cap_b_w.delete(); cap_b_d.delete();
   endtask

   task automatic check_frames(input int sel, input string tag, input int base,
                               input int w, input int h, input int frames);
      logic [71:0] ew[$];
      bit          ed[$];
      logic [71:0] gw[$];
      bit          gd[$];
      repeat (3) @(posedge clk);
      #1;
      for (int f = 0; f < frames; f++)
         for (int wr = 0; wr <= h - 3; wr++)
            for (int wc = 0; wc <= w - 3; wc++) begin
               ew.push_back(exp_win(base + f * w * h, w, wr, wc));
               ed.push_back(wr == h - 3 && wc == w - 3);
            end
      if (sel == 0) begin gw = cap_a_w; gd = cap_a_d; end
      else          begin gw = cap_b_w; gd = cap_b_d; end
      chk({tag, " count"}, gw.size(), ew.size());
      for (int i = 0; i < ew.size() && i < gw.size(); i++) begin
         chk($sformatf("%s win%0d", tag, i), gw[i], ew[i]);
         chk($sformatf("%s done%0d", tag, i), gd[i], ed[i]);
      end
   endtask

   initial begin
      int ndone;
      ifa.pixel_valid = 1'b0; ifa.pixel_in = '0; ifa.window_ready = 1'b1;
      ifb.pixel_valid = 1'b0; ifb.pixel_in = '0; ifb.window_ready = 1'b1;

      #3;
      chk("reset wv", ifa.window_valid, 0);
      chk("reset window", ifa.window, 0);
      chk("reset fdone", ifa.frame_done, 0);
      chk("reset pready", ifa.pixel_ready, 1);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      chk("after reset pready", ifa.pixel_ready, 1);

      // Continuous stream, consumer always ready.
      for (int v = 0; v < 16; v++) begin
         send(0, v);
         if (v == 9)  chk("no win before px10", ifa.window_valid, 0);
         if (v == 10) begin
            chk("lat1 wv", ifa.window_valid, 1);
            chk("first win", ifa.window, 72'h0A_09_08_06_05_04_02_01_00);
            chk("first fdone", ifa.frame_done, 0);
         end
         if (v == 11) chk("second win", ifa.window, 72'h0B_0A_09_07_06_05_03_02_01);
         if (v == 15) begin
            chk("last wv", ifa.window_valid, 1);
            chk("last fdone", ifa.frame_done, 1);
         end
      end
      @(posedge clk); #1;
      chk("wv falls", ifa.window_valid, 0);
      chk("fdone falls", ifa.frame_done, 0);
      check_frames(0, "stream", 0, 4, 4, 1);

      // Consumer stall for 5 cycles after the first window.
      pulse_reset();
      for (int v = 0; v <= 10; v++) send(0, v);
      ifa.pixel_valid = 1'b1; ifa.pixel_in = 8'd11; ifa.window_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("stall wv %0d", i), ifa.window_valid, 1);
         chk($sformatf("stall win %0d", i), ifa.window, 72'h0A_09_08_06_05_04_02_01_00);
         chk($sformatf("stall pready %0d", i), ifa.pixel_ready, 0);
      end
      @(posedge clk); #1;
      ifa.window_ready = 1'b1;
      for (int v = 11; v < 16; v++) send(0, v);
      check_frames(0, "stall", 0, 4, 4, 1);

      // pixel_valid toggling every cycle.
      pulse_reset();
      for (int v = 0; v < 16; v++) begin
         send(0, v);
         @(posedge clk); #1;
      end
      check_frames(0, "gaps", 0, 4, 4, 1);

      // Reset mid-frame after pixel 7.
      pulse_reset();
      for (int v = 0; v < 8; v++) send(0, v);
      pulse_reset();
      for (int v = 100; v < 116; v++) begin
         send(0, v);
         if (v == 110) chk("post-rst first win", ifa.window, 72'h6E_6D_6C_6A_69_68_66_65_64);
      end
      check_frames(0, "midrst", 100, 4, 4, 1);

      // Two frames back to back.
      pulse_reset();
      for (int v = 0; v < 32; v++) begin
         send(0, v);
         if (v == 26) chk("frame2 first win", ifa.window, 72'h1A_19_18_16_15_14_12_11_10);
      end
      check_frames(0, "b2b", 0, 4, 4, 2);
      ndone = 0;
      foreach (cap_a_d[i]) if (cap_a_d[i]) ndone++;
      chk("b2b fdone count", ndone, 2);

      // Wide short frame on the 8x3 instance.
      pulse_reset();
      for (int v = 0; v < 24; v++) send(1, v);
      check_frames(1, "w8h3", 0, 8, 3, 1);
      ndone = 0;
      foreach (cap_b_d[i]) if (cap_b_d[i]) ndone++;
      chk("w8h3 fdone count", ndone, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
